// File: rtl/rmap_reply_tx.sv
// RMAP reply packet assembler: header + header CRC, optional read data + data CRC,
// terminated with EOP (or EEP on abort), written one character per cycle into the TX FIFO.
module rmap_reply_tx #(
  parameter int LEN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isRead,
  input  logic [7:0]       initiatorLa,
  input  logic [7:0]       instruction,
  input  logic [7:0]       status,
  input  logic [7:0]       targetLa,
  input  logic [15:0]      transactionId,
  input  logic [LEN_W-1:0] dataLength,
  input  logic [7:0]       dataIn,
  input  logic             dataValid,
  output logic             dataReady,
  input  logic             abort,
  output logic             txWriteEnable,
  output logic [8:0]       txDataIn,
  input  logic             txFull,
  output logic             busy,
  output logic             done,
  output logic             doneErr
);

  typedef enum logic [2:0] {IDLE, HDR, HCRC, DATA, DCRC, EOP, EEP} state_t;

  state_t           state, stateNext;
  logic [3:0]       hdrIdx, hdrIdxNext;
  logic [LEN_W-1:0] remaining, remainingNext;
  logic [7:0]       crc, crcNext;
  logic             emit;
  logic [7:0]       hdrByte;
  logic             hdrLast;
  logic [7:0]       crcUpd;

  logic             readReg;
  logic [7:0]       iLaReg, instrReg, statusReg, tLaReg;
  logic [15:0]      tidReg;
  logic [23:0]      lenReg;

  // Reflected form of x^8+x^2+x+1 (0x07 -> 0xE0), LSB first, no final XOR.
  function automatic logic [7:0] crcByte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 8'hE0) : (x >> 1);
    end
    return x;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readReg   <= 1'b0;
      iLaReg    <= 8'h00;
      instrReg  <= 8'h00;
      statusReg <= 8'h00;
      tLaReg    <= 8'h00;
      tidReg    <= 16'h0000;
      lenReg    <= 24'h000000;
    end else if (state == IDLE && start) begin
      readReg   <= isRead;
      iLaReg    <= initiatorLa;
      instrReg  <= instruction;
      statusReg <= status;
      tLaReg    <= targetLa;
      tidReg    <= transactionId;
      lenReg    <= 24'(dataLength);
    end
  end

  always_comb begin
    hdrByte = 8'h00;
    case (hdrIdx)
      4'd0:    hdrByte = iLaReg;
      4'd1:    hdrByte = 8'h01;
      4'd2:    hdrByte = instrReg;
      4'd3:    hdrByte = statusReg;
      4'd4:    hdrByte = tLaReg;
      4'd5:    hdrByte = tidReg[15:8];
      4'd6:    hdrByte = tidReg[7:0];
      4'd7:    hdrByte = 8'h00;
      4'd8:    hdrByte = lenReg[23:16];
      4'd9:    hdrByte = lenReg[15:8];
      4'd10:   hdrByte = lenReg[7:0];
      default: hdrByte = 8'h00;
    endcase
  end

  assign hdrLast = readReg ? (hdrIdx == 4'd10) : (hdrIdx == 4'd6);

  always_comb begin
    emit      = 1'b0;
    txDataIn  = 9'h000;
    dataReady = 1'b0;
    case (state)
      HDR: begin
        emit     = 1'b1;
        txDataIn = {1'b0, hdrByte};
      end
      HCRC, DCRC: begin
        emit     = 1'b1;
        txDataIn = {1'b0, crc};
      end
      DATA: begin
        emit      = dataValid;
        dataReady = !txFull;
        txDataIn  = {1'b0, dataIn};
      end
      EOP: begin
        emit     = 1'b1;
        txDataIn = 9'h100;
      end
      EEP: begin
        emit     = 1'b1;
        txDataIn = 9'h101;
      end
      default: ;
    endcase
  end

  assign txWriteEnable = emit && !txFull;
  assign busy          = (state != IDLE);
  assign done          = txWriteEnable && (state == EOP || state == EEP);
  assign doneErr       = txWriteEnable && (state == EEP);
  assign crcUpd        = crcByte(crc, txDataIn[7:0]);

  always_comb begin
    stateNext     = state;
    hdrIdxNext    = hdrIdx;
    remainingNext = remaining;
    crcNext       = crc;
    case (state)
      IDLE: if (start) begin
        stateNext     = HDR;
        hdrIdxNext    = 4'd0;
        crcNext       = 8'h00;
        remainingNext = dataLength;
      end
      HDR: if (txWriteEnable) begin
        crcNext    = crcUpd;
        hdrIdxNext = hdrIdx + 4'd1;
        if (hdrLast) stateNext = HCRC;
      end
      HCRC: if (txWriteEnable) begin
        // Data CRC starts fresh; it never covers header bytes.
        crcNext = 8'h00;
        if (!readReg)                  stateNext = EOP;
        else if (remaining == '0)      stateNext = DCRC;
        else                           stateNext = DATA;
      end
      DATA: if (txWriteEnable) begin
        crcNext       = crcUpd;
        remainingNext = remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) stateNext = DCRC;
      end
      DCRC: if (txWriteEnable) stateNext = EOP;
      EOP, EEP: if (txWriteEnable) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (abort && (state == HDR || state == HCRC || state == DATA || state == DCRC))
      stateNext = EEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hdrIdx    <= 4'd0;
      remaining <= '0;
      crc       <= 8'h00;
    end else begin
      state     <= stateNext;
      hdrIdx    <= hdrIdxNext;
      remaining <= remainingNext;
      crc       <= crcNext;
    end
  end

endmodule

// File: tb/tb_rmap_reply_tx.sv
// Scoreboard bench for rmap_reply_tx: expected characters are queued from a CRC model
// when a reply is requested, and compared against the characters the FIFO port writes.
module tb_rmap_reply_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        isRead = 1'b0;
  logic [7:0]  initiatorLa = 8'h00;
  logic [7:0]  instruction = 8'h00;
  logic [7:0]  status = 8'h00;
  logic [7:0]  targetLa = 8'h00;
  logic [15:0] transactionId = 16'h0000;
  logic [23:0] dataLength = 24'h0;
  logic [7:0]  dataIn = 8'h00;
  logic        dataValid = 1'b0;
  logic        dataReady;
  logic        abort = 1'b0;
  logic        txWriteEnable;
  logic [8:0]  txDataIn;
  logic        txFull = 1'b0;
  logic        busy;
  logic        done;
  logic        doneErr;

  rmap_reply_tx #(.LEN_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .isRead(isRead),
    .initiatorLa(initiatorLa), .instruction(instruction), .status(status),
    .targetLa(targetLa), .transactionId(transactionId), .dataLength(dataLength),
    .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady), .abort(abort),
    .txWriteEnable(txWriteEnable), .txDataIn(txDataIn), .txFull(txFull),
    .busy(busy), .done(done), .doneErr(doneErr)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp[$];
  logic [8:0] got[$];
  logic [7:0] dataBytes[16];
  int         iters, doneCnt, doneErrCnt, fullViol, readyViol;
  bit         timedOut, busySeen;

  // Serial model: one message bit at a time, LSB first.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[7:1]};
      if (fb) r = r ^ 8'hE0;
    end
    return r;
  endfunction

  function automatic void push_reply(input bit rd, input int nData, input int abortAt);
    logic [7:0] h[$];
    logic [7:0] c;
    int n;
    h.push_back(initiatorLa); h.push_back(8'h01); h.push_back(instruction);
    h.push_back(status); h.push_back(targetLa);
    h.push_back(transactionId[15:8]); h.push_back(transactionId[7:0]);
    if (rd) begin
      h.push_back(8'h00); h.push_back(dataLength[23:16]);
      h.push_back(dataLength[15:8]); h.push_back(dataLength[7:0]);
    end
    c = 8'h00;
    foreach (h[i]) begin
      exp.push_back({1'b0, h[i]});
      c = crc8(c, h[i]);
    end
    exp.push_back({1'b0, c});
    if (rd) begin
      c = 8'h00;
      n = (abortAt >= 0) ? abortAt : nData;
      for (int i = 0; i < n; i++) begin
        exp.push_back({1'b0, dataBytes[i]});
        c = crc8(c, dataBytes[i]);
      end
      if (abortAt >= 0) begin
        exp.push_back(9'h101);
        return;
      end
      exp.push_back({1'b0, c});
    end
    exp.push_back(9'h100);
  endfunction

  // Requests one reply and captures every written character until done or the cycle budget.
  task automatic drive_packet(input int maxCyc, input bit toggleFull, input int abortAt,
                              input int nData, input bit abortWithStart);
    int idx;
    bit fin, aborted;
    got.delete();
    iters = 0; doneCnt = 0; doneErrCnt = 0; fullViol = 0; readyViol = 0;
    timedOut = 0; busySeen = 0; idx = 0; fin = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1; abort = abortWithStart; txFull = 1'b0;
    for (int c = 0; c < maxCyc && !fin; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 0) begin
        initiatorLa = 8'($urandom); instruction = 8'($urandom); status = 8'($urandom);
        targetLa = 8'($urandom); transactionId = 16'($urandom);
        dataLength = 24'($urandom); isRead = 1'($urandom);
      end
      txFull    = toggleFull && (c % 2 == 0);
      abort     = !aborted && (abortAt >= 0) && (idx == abortAt);
      dataValid = (idx < nData) && !abort;
      dataIn    = (idx < nData) ? dataBytes[idx] : 8'h00;
      #1;
      if (c == 0) busySeen = busy;
      if (txWriteEnable && txFull) fullViol++;
      if (dataReady && txFull) readyViol++;
      if (txWriteEnable) got.push_back(txDataIn);
      if (dataValid && dataReady) idx++;
      if (abort) aborted = 1;
      if (done) begin
        doneCnt++;
        if (doneErr) doneErrCnt++;
        fin = 1;
      end
      iters++;
    end
    start = 1'b0; abort = 1'b0; txFull = 1'b0;
    if (!fin) timedOut = 1;
  endtask

  task automatic set_fields(input bit rd, input logic [7:0] ila, input logic [7:0] ins,
                            input logic [7:0] st, input logic [7:0] tla,
                            input logic [15:0] tid, input logic [23:0] len);
    isRead = rd; initiatorLa = ila; instruction = ins; status = st;
    targetLa = tla; transactionId = tid; dataLength = len;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    dataValid = 1'b1; txFull = 1'b0;
    #1;
    vectors++;
    if ({txWriteEnable, txDataIn, dataReady, busy, done, doneErr} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: we=%b data=%h rdy=%b busy=%b done=%b err=%b, required all 0",
               txWriteEnable, txDataIn, dataReady, busy, done, doneErr);
    end
    @(negedge clk); rst = 1'b0; dataValid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (txWriteEnable !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: we=%b busy=%b, required 0 0", txWriteEnable, busy);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_write_reply;
    logic [8:0] e, a;
    logic [7:0] c;
    set_fields(0, 8'hFE, 8'h2C, 8'h00, 8'h20, 16'h1234, 24'h0);
    push_reply(0, 0, -1);
    drive_packet(40, 0, -1, 0, 1);
    vectors++;
    if (timedOut || got.size() != exp.size() || iters != 9) begin
      miscompares++;
      $display("FAIL write_count: got %0d chars in %0d cycles (timeout=%0d), required %0d in 9",
               got.size(), iters, timedOut, exp.size());
    end
    for (int i = 0; exp.size() > 0; i++) begin
      e = exp.pop_front(); a = 9'bx;
      if (i < got.size()) a = got[i];
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL write_char[%0d]: got %h, required %h", i, a, e);
      end
    end
    c = 8'h00;
    for (int i = 0; i < 8 && i < got.size(); i++) c = crc8(c, got[i][7:0]);
    vectors++;
    if (c !== 8'h00) begin
      miscompares++;
      $display("FAIL write_crc_residue: got %h, required 00", c);
    end
    vectors++;
    if (doneCnt != 1 || doneErrCnt != 0 || !busySeen) begin
      miscompares++;
      $display("FAIL write_done: done=%0d doneErr=%0d busy=%0d, required 1 0 1",
               doneCnt, doneErrCnt, busySeen);
    end
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write_busy_after: got %b, required 0", busy);
    end
    $display("write_reply: %0d chars written", got.size());
  endtask

  task automatic test_read_reply(input bit toggleFull);
    logic [8:0] e, a;
    logic [7:0] ch, cd;
    for (int i = 0; i < 4; i++) dataBytes[i] = 8'hA0 + 8'(i);
    set_fields(1, 8'hFE, 8'h0C, 8'h00, 8'h20, 16'hBEEF, 24'd4);
    push_reply(1, 4, -1);
    drive_packet(100, toggleFull, -1, 4, 0);
    vectors++;
    if (timedOut || got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL read_count(full=%0d): got %0d chars (timeout=%0d), required %0d",
               toggleFull, got.size(), timedOut, exp.size());
    end
    for (int i = 0; exp.size() > 0; i++) begin
      e = exp.pop_front(); a = 9'bx;
      if (i < got.size()) a = got[i];
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL read_char[%0d](full=%0d): got %h, required %h", i, toggleFull, a, e);
      end
    end
    ch = 8'h00; cd = 8'h00;
    for (int i = 0; i < 12 && i < got.size(); i++) ch = crc8(ch, got[i][7:0]);
    for (int i = 12; i < 17 && i < got.size(); i++) cd = crc8(cd, got[i][7:0]);
    vectors++;
    if (ch !== 8'h00 || cd !== 8'h00) begin
      miscompares++;
      $display("FAIL read_crc_residue: header %h data %h, required 00 00", ch, cd);
    end
    vectors++;
    if (fullViol != 0 || readyViol != 0 || doneCnt != 1 || doneErrCnt != 0) begin
      miscompares++;
      $display("FAIL read_flow(full=%0d): writesWhileFull=%0d readyWhileFull=%0d done=%0d err=%0d, required 0 0 1 0",
               toggleFull, fullViol, readyViol, doneCnt, doneErrCnt);
    end
    $display("read_reply(full toggling=%0d): %0d chars written in %0d cycles", toggleFull, got.size(), iters);
  endtask

  task automatic test_zero_len;
    logic [8:0] e, a;
    set_fields(1, 8'h55, 8'h0C, 8'h03, 8'h21, 16'h0001, 24'd0);
    push_reply(1, 0, -1);
    drive_packet(60, 0, -1, 0, 0);
    vectors++;
    if (timedOut || got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL zero_count: got %0d chars, required %0d", got.size(), exp.size());
    end
    for (int i = 0; exp.size() > 0; i++) begin
      e = exp.pop_front(); a = 9'bx;
      if (i < got.size()) a = got[i];
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL zero_char[%0d]: got %h, required %h", i, a, e);
      end
    end
    $display("zero_len_read: %0d chars written", got.size());
  endtask

  task automatic test_abort;
    logic [8:0] e, a;
    for (int i = 0; i < 6; i++) dataBytes[i] = 8'h30 + 8'(i * 7);
    set_fields(1, 8'h42, 8'h0D, 8'h00, 8'hFE, 16'hCAFE, 24'd6);
    push_reply(1, 6, 2);
    drive_packet(80, 0, 2, 6, 0);
    vectors++;
    if (timedOut || got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL abort_count: got %0d chars, required %0d", got.size(), exp.size());
    end
    for (int i = 0; exp.size() > 0; i++) begin
      e = exp.pop_front(); a = 9'bx;
      if (i < got.size()) a = got[i];
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL abort_char[%0d]: got %h, required %h", i, a, e);
      end
    end
    vectors++;
    if (doneCnt != 1 || doneErrCnt != 1) begin
      miscompares++;
      $display("FAIL abort_done: done=%0d doneErr=%0d, required 1 1", doneCnt, doneErrCnt);
    end
    $display("abort: %0d chars written, ended with EEP", got.size());
  endtask

  task automatic test_reset_mid;
    logic [8:0] e, a;
    for (int i = 0; i < 4; i++) dataBytes[i] = 8'hC0 + 8'(i);
    set_fields(1, 8'h11, 8'h0C, 8'h00, 8'h22, 16'h7777, 24'd4);
    drive_packet(13, 0, -1, 4, 0);
    @(negedge clk); #1;
    vectors++;
    if (txWriteEnable !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre: we=%b busy=%b, required 1 1", txWriteEnable, busy);
    end
    rst = 1'b1; #1;
    vectors++;
    if (txWriteEnable !== 1'b0 || busy !== 1'b0 || dataReady !== 1'b0 || txDataIn !== 9'h000) begin
      miscompares++;
      $display("FAIL midreset_async: we=%b busy=%b rdy=%b data=%h, required 0 0 0 000",
               txWriteEnable, busy, dataReady, txDataIn);
    end
    @(negedge clk); rst = 1'b0; dataValid = 1'b0;
    set_fields(0, 8'h99, 8'h3C, 8'h05, 8'h44, 16'hA55A, 24'h0);
    push_reply(0, 0, -1);
    drive_packet(40, 0, -1, 0, 0);
    vectors++;
    if (timedOut || got.size() != exp.size()) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d chars, required %0d", got.size(), exp.size());
    end
    for (int i = 0; exp.size() > 0; i++) begin
      e = exp.pop_front(); a = 9'bx;
      if (i < got.size()) a = got[i];
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL midreset_char[%0d]: got %h, required %h", i, a, e);
      end
    end
    $display("reset_mid_packet: follow-up write reply %0d chars", got.size());
  endtask

  task automatic test_back_to_back;
    logic [8:0] e, a;
    for (int p = 0; p < 2; p++) begin
      set_fields(0, 8'(8'hE0 + p), 8'h2C, 8'(p), 8'h10, 16'(16'h0100 * (p + 1)), 24'h0);
      push_reply(0, 0, -1);
      drive_packet(40, 0, -1, 0, 0);
      vectors++;
      if (timedOut || got.size() != exp.size()) begin
        miscompares++;
        $display("FAIL b2b_count[%0d]: got %0d chars, required %0d", p, got.size(), exp.size());
      end
      for (int i = 0; exp.size() > 0; i++) begin
        e = exp.pop_front(); a = 9'bx;
        if (i < got.size()) a = got[i];
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL b2b_char[%0d][%0d]: got %h, required %h", p, i, a, e);
        end
      end
      $display("back_to_back[%0d]: %0d chars written", p, got.size());
    end
  endtask

  initial begin
    test_reset;
    test_write_reply;
    test_read_reply(0);
    test_read_reply(1);
    test_zero_len;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
